// File: rtl/pc_unit_pkg.sv
// Shared next-PC definitions: the D-stage selector encoding, the control-transfer
// classifier and the default reset/handler addresses.
package npc_defs;

    typedef enum logic [3:0] {
        SEL_SEQ  = 4'd0,
        SEL_BEQ  = 4'd1,
        SEL_JR   = 4'd2,
        SEL_J    = 4'd3,
        SEL_BNE  = 4'd4,
        SEL_BLEZ = 4'd5,
        SEL_BGEZ = 4'd6,
        SEL_BGTZ = 4'd7,
        SEL_BLTZ = 4'd8,
        SEL_ERET = 4'd9
    } sel_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

    // A control transfer owns a delay slot whether or not it is taken.
    function automatic logic is_ctrl(input logic [3:0] sel);
        logic ctrl;
        case (sel_e'(sel))
            SEL_BEQ, SEL_BNE, SEL_BLEZ, SEL_BGEZ,
            SEL_BGTZ, SEL_BLTZ, SEL_J, SEL_JR: ctrl = 1'b1;
            default:                           ctrl = 1'b0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: decides whether the selected next-PC kind redirects,
// given the forwarded rs/rt values. Kept standalone for reuse in the E stage.
module branch_cmp
    import npc_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             cond
);

    logic sign_s;
    logic zero_s;

    assign sign_s = rs_val[WIDTH-1];
    assign zero_s = (rs_val == {WIDTH{1'b0}});

    // Signed compares against zero reduce to the sign bit and a zero test.
    always_comb begin
        cond = 1'b0;
        case (sel_e'(sel))
            SEL_BEQ:         cond = (rs_val == rt_val);
            SEL_BNE:         cond = (rs_val != rt_val);
            SEL_BLEZ:        cond = sign_s | zero_s;
            SEL_BGEZ:        cond = ~sign_s;
            SEL_BGTZ:        cond = ~sign_s & ~zero_s;
            SEL_BLTZ:        cond = sign_s;
            SEL_J, SEL_JR:   cond = 1'b1;
            default:         cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: owns pc_f, selects among sequential, branch, jump,
// eret and exception-entry sources, and tracks delay-slot and fetch-fault status.
module pc_unit
    import npc_defs::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [WIDTH-1:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [WIDTH-1:0] IM_BASE    = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             int_req,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [15:0]      imm16,
    input  logic [25:0]      index26,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc4_f,
    output logic             taken,
    output logic             flush_f,
    output logic             f_bd,
    output logic             f_adel
);

    logic [WIDTH-1:0] pc_f_r;
    logic             f_bd_r;
    logic [WIDTH-1:0] pc_next_s;
    logic             bd_next_s;
    logic             cond_s;
    logic             is_eret_s;
    logic [WIDTH-1:0] pc4_d_s;
    logic [WIDTH-1:0] br_off_s;
    logic [WIDTH-1:0] br_target_s;
    logic [WIDTH-1:0] j_target_s;
    logic [WIDTH-1:0] target_s;

    branch_cmp #(.WIDTH(WIDTH)) u_branch_cmp (
        .sel    (sel),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cond   (cond_s)
    );

    assign is_eret_s   = (sel == SEL_ERET);
    assign pc4_d_s     = pc_d + WIDTH'(4);
    assign br_off_s    = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign br_target_s = pc4_d_s + br_off_s;
    assign j_target_s  = {pc4_d_s[WIDTH-1:28], index26, 2'b00};

    assign taken   = cond_s & ~stall & ~int_req;
    assign flush_f = int_req | (is_eret_s & ~stall);

    // Redirect target by transfer kind; branches share one adder.
    always_comb begin
        target_s = br_target_s;
        case (sel_e'(sel))
            SEL_J:   target_s = j_target_s;
            SEL_JR:  target_s = rs_val;
            default: target_s = br_target_s;
        endcase
    end

    // Next-PC priority: exception entry beats stall, stall beats eret and redirects.
    always_comb begin
        pc_next_s = pc_f_r + WIDTH'(4);
        bd_next_s = is_ctrl(sel);
        if (int_req) begin
            pc_next_s = HANDLER_PC;
            bd_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s = pc_f_r;
            bd_next_s = f_bd_r;
        end else if (is_eret_s) begin
            pc_next_s = epc;
            bd_next_s = 1'b0;
        end else if (taken) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_f_r + WIDTH'(4);
        end
    end

    // PC and delay-slot flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_r <= RESET_PC;
            f_bd_r <= 1'b0;
        end else begin
            pc_f_r <= pc_next_s;
            f_bd_r <= bd_next_s;
        end
    end

    assign pc_f   = pc_f_r;
    assign f_bd   = f_bd_r;
    assign pc4_f  = pc_f_r + WIDTH'(4);
    assign f_adel = (pc_f_r[1:0] != 2'b00) | (pc_f_r < IM_BASE) | (pc_f_r > IM_LIMIT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        int_req;
    logic [3:0]  sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        taken;
    logic        flush_f;
    logic        f_bd;
    logic        f_adel;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .int_req (int_req),
        .sel     (sel),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .pc_d    (pc_d),
        .imm16   (imm16),
        .index26 (index26),
        .epc     (epc),
        .pc_f    (pc_f),
        .pc4_f   (pc4_f),
        .taken   (taken),
        .flush_f (flush_f),
        .f_bd    (f_bd),
        .f_adel  (f_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (pc_f !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_f, 32'h0000_3000); end
        n_checks++; if (f_bd !== 1'b0) begin n_fail++; $display("FAIL reset_bd: got %b expected 0", f_bd); end
        n_checks++; if (pc4_f !== 32'h0000_3004) begin n_fail++; $display("FAIL reset_pc4: got %h expected %h", pc4_f, 32'h0000_3004); end
        n_checks++; if (f_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel: got %b expected 0", f_adel); end
        reset = 1'b0;
        tick();
        n_checks++; if (pc_f !== 32'h0000_3004) begin n_fail++; $display("FAIL seq1_pc: got %h expected %h", pc_f, 32'h0000_3004); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3008) begin n_fail++; $display("FAIL seq2_pc: got %h expected %h", pc_f, 32'h0000_3008); end
    endtask

    task automatic test_branch();
        pc_d = 32'h0000_3010; sel = 4'd1; rs_val = 32'd5; rt_val = 32'd5; imm16 = 16'hFFFC;
        #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3004) begin n_fail++; $display("FAIL beq_pc: got %h expected %h", pc_f, 32'h0000_3004); end
        n_checks++; if (f_bd !== 1'b1) begin n_fail++; $display("FAIL beq_bd: got %b expected 1", f_bd); end
        rt_val = 32'd6;
        #1;
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL beq_nt_taken: got %b expected 0", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3008) begin n_fail++; $display("FAIL beq_nt_pc: got %h expected %h", pc_f, 32'h0000_3008); end
        n_checks++; if (f_bd !== 1'b1) begin n_fail++; $display("FAIL beq_nt_bd: got %b expected 1", f_bd); end
        sel = 4'd0;
        tick();
        n_checks++; if (f_bd !== 1'b0) begin n_fail++; $display("FAIL seq_bd: got %b expected 0", f_bd); end
    endtask

    task automatic test_conditions();
        sel = 4'd8; rs_val = 32'h8000_0000; #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL bltz_taken: got %b expected 1", taken); end
        sel = 4'd7; rs_val = 32'h0; #1;
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL bgtz_taken: got %b expected 0", taken); end
        sel = 4'd5; rs_val = 32'h0; #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL blez_taken: got %b expected 1", taken); end
        sel = 4'd6; rs_val = 32'hFFFF_FFFF; #1;
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL bgez_taken: got %b expected 0", taken); end
        sel = 4'd4; rs_val = 32'd1; rt_val = 32'd2; #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL bne_taken: got %b expected 1", taken); end
        sel = 4'd2; rs_val = 32'h0000_3402; #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL jr_taken: got %b expected 1", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3402) begin n_fail++; $display("FAIL jr_pc: got %h expected %h", pc_f, 32'h0000_3402); end
        n_checks++; if (f_adel !== 1'b1) begin n_fail++; $display("FAIL jr_adel: got %b expected 1", f_adel); end
        n_checks++; if (f_bd !== 1'b1) begin n_fail++; $display("FAIL jr_bd: got %b expected 1", f_bd); end
    endtask

    task automatic test_stall();
        // f_bd is 1 from the jr, so the hold of both registers is observable.
        stall = 1'b1; sel = 4'd3; pc_d = 32'h0000_3000; index26 = 26'h0000C10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL stall_taken[%0d]: got %b expected 0", i, taken); end
            tick();
            n_checks++; if (pc_f !== 32'h0000_3402) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_f, 32'h0000_3402); end
            n_checks++; if (f_bd !== 1'b1) begin n_fail++; $display("FAIL stall_bd[%0d]: got %b expected 1", i, f_bd); end
        end
        int_req = 1'b1; #1;
        n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL int_flush: got %b expected 1", flush_f); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_4180) begin n_fail++; $display("FAIL int_pc: got %h expected %h", pc_f, 32'h0000_4180); end
        n_checks++; if (f_bd !== 1'b0) begin n_fail++; $display("FAIL int_bd: got %b expected 0", f_bd); end
        stall = 1'b0; int_req = 1'b0; sel = 4'd0;
    endtask

    task automatic test_eret();
        stall = 1'b1; sel = 4'd9; epc = 32'h0000_3020; #1;
        n_checks++; if (flush_f !== 1'b0) begin n_fail++; $display("FAIL eret_stall_flush: got %b expected 0", flush_f); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_4180) begin n_fail++; $display("FAIL eret_stall_pc: got %h expected %h", pc_f, 32'h0000_4180); end
        stall = 1'b0; #1;
        n_checks++; if (flush_f !== 1'b1) begin n_fail++; $display("FAIL eret_flush: got %b expected 1", flush_f); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3020) begin n_fail++; $display("FAIL eret_pc: got %h expected %h", pc_f, 32'h0000_3020); end
        n_checks++; if (f_bd !== 1'b0) begin n_fail++; $display("FAIL eret_bd: got %b expected 0", f_bd); end
        sel = 4'd0;
        tick();
        n_checks++; if (pc_f !== 32'h0000_3024) begin n_fail++; $display("FAIL post_eret_pc: got %h expected %h", pc_f, 32'h0000_3024); end
        reset = 1'b1; int_req = 1'b1;
        tick();
        n_checks++; if (pc_f !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_int_pc: got %h expected %h", pc_f, 32'h0000_3000); end
        reset = 1'b0; int_req = 1'b0;
    endtask

    task automatic test_jump();
        sel = 4'd3; pc_d = 32'h0000_3000; index26 = 26'h0000C10; #1;
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL j_taken: got %b expected 1", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3040) begin n_fail++; $display("FAIL j_pc: got %h expected %h", pc_f, 32'h0000_3040); end
        n_checks++; if (f_bd !== 1'b1) begin n_fail++; $display("FAIL j_bd: got %b expected 1", f_bd); end
        sel = 4'd15; #1;
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL undef_taken: got %b expected 0", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_3044) begin n_fail++; $display("FAIL undef_pc: got %h expected %h", pc_f, 32'h0000_3044); end
        n_checks++; if (f_bd !== 1'b0) begin n_fail++; $display("FAIL undef_bd: got %b expected 0", f_bd); end
    endtask

    task automatic test_boundaries();
        // Interrupt beats a taken jump.
        sel = 4'd3; int_req = 1'b1; #1;
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL int_j_taken: got %b expected 0", taken); end
        tick();
        n_checks++; if (pc_f !== 32'h0000_4180) begin n_fail++; $display("FAIL int_j_pc: got %h expected %h", pc_f, 32'h0000_4180); end
        int_req = 1'b0;
        sel = 4'd2; rs_val = 32'h0000_6FFC;
        tick();
        n_checks++; if (f_adel !== 1'b0) begin n_fail++; $display("FAIL limit_adel: got %b expected 0", f_adel); end
        sel = 4'd0;
        tick();
        n_checks++; if (pc_f !== 32'h0000_7000) begin n_fail++; $display("FAIL above_pc: got %h expected %h", pc_f, 32'h0000_7000); end
        n_checks++; if (f_adel !== 1'b1) begin n_fail++; $display("FAIL above_adel: got %b expected 1", f_adel); end
        sel = 4'd2; rs_val = 32'hFFFF_FFFC;
        tick();
        n_checks++; if (pc4_f !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc4: got %h expected %h", pc4_f, 32'h0000_0000); end
        sel = 4'd0;
        tick();
        n_checks++; if (pc_f !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc_f, 32'h0000_0000); end
        n_checks++; if (f_adel !== 1'b1) begin n_fail++; $display("FAIL below_adel: got %b expected 1", f_adel); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; int_req = 1'b0; sel = 4'd0;
        rs_val = 32'h0; rt_val = 32'h0; pc_d = 32'h0; imm16 = 16'h0;
        index26 = 26'h0; epc = 32'h0;
        test_reset();
        test_branch();
        test_conditions();
        test_stall();
        test_eret();
        test_jump();
        test_boundaries();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
